// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, the ID/EX slot bundle and register-usage helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Output-slot occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    // Everything EX needs from the decode stage
    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] immediate;
        logic [31:0] pc;
    } id_ex_t;

    // Jumps carry a target in the rs field position, so rs is not a real source
    function automatic logic rs_used(input logic [5:0] op);
        return !((op == OP_J) || (op == OP_JAL));
    endfunction

    // Only R-type, branches and stores actually read rt
    function automatic logic rt_used(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-port operand select: $0 reads as zero, a same-cycle write-back wins over
// the register file, otherwise the register-file read data is used.
module operand_bypass
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  i_wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] i_wb_write_address,
    input  logic [DATA_WIDTH-1:0] i_wb_write_data,
    output logic [DATA_WIDTH-1:0] o_operand
);

    // Priority select: zero register, then write-back bypass, then register file
    always_comb begin
        o_operand = i_read_data;
        if (i_address == '0) begin
            o_operand = '0;
        end else if (i_wb_reg_write && (i_wb_write_address == i_address)) begin
            o_operand = i_wb_write_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives register-file read addresses, captures the
// operands (with write-back bypass) into a single ID/EX slot guarded by a
// valid/ready handshake, and stalls upstream on load-use hazards.
module operand_fetch_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] pcIn,
    output logic [ADDR_WIDTH-1:0] readAddress1,
    output logic [ADDR_WIDTH-1:0] readAddress2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic                  wbRegWrite,
    input  logic [ADDR_WIDTH-1:0] wbWriteAddress,
    input  logic [DATA_WIDTH-1:0] wbWriteData,
    input  logic                  exMemRead,
    input  logic [ADDR_WIDTH-1:0] exWriteAddress,
    input  logic                  flush,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outOperandA,
    output logic [DATA_WIDTH-1:0] outOperandB,
    output logic [DATA_WIDTH-1:0] outImmediate,
    output logic [5:0]            outOpcode,
    output logic [5:0]            outFunct,
    output logic [ADDR_WIDTH-1:0] outRs,
    output logic [ADDR_WIDTH-1:0] outRt,
    output logic [ADDR_WIDTH-1:0] outRd,
    output logic [DATA_WIDTH-1:0] outPc,
    output logic [CNT_WIDTH-1:0]  stallCount
);

    slot_state_t             r_state;
    slot_state_t             w_state_next;
    id_ex_t                  r_slot;
    id_ex_t                  w_load;
    logic [CNT_WIDTH-1:0]    r_stall_count;

    logic [5:0]              w_opcode;
    logic [ADDR_WIDTH-1:0]   w_rs;
    logic [ADDR_WIDTH-1:0]   w_rt;
    logic [DATA_WIDTH-1:0]   w_operand_a;
    logic [DATA_WIDTH-1:0]   w_operand_b;
    logic                    w_hazard;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_hold;

    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];

    assign readAddress1 = w_rs;
    assign readAddress2 = w_rt;

    // A load in EX whose destination is a source we really read must wait a cycle
    assign w_hazard = inValid && exMemRead && (exWriteAddress != '0) &&
                      (((exWriteAddress == w_rs) && rs_used(w_opcode)) ||
                       ((exWriteAddress == w_rt) && rt_used(w_opcode)));

    assign w_in_ready = !flush && !w_hazard && ((r_state == ST_EMPTY) || outReady);
    assign w_accept   = inValid && w_in_ready;
    // Slot occupied and EX not taking it: operands may still be refreshed by WB
    assign w_hold     = (r_state == ST_FULL) && !outReady && !flush;
    assign inReady    = w_in_ready;

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_a (
        .i_address          (w_rs),
        .i_read_data        (readData1),
        .i_wb_reg_write     (wbRegWrite),
        .i_wb_write_address (wbWriteAddress),
        .i_wb_write_data    (wbWriteData),
        .o_operand          (w_operand_a)
    );

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_b (
        .i_address          (w_rt),
        .i_read_data        (readData2),
        .i_wb_reg_write     (wbRegWrite),
        .i_wb_write_address (wbWriteAddress),
        .i_wb_write_data    (wbWriteData),
        .o_operand          (w_operand_b)
    );

    // Assemble the bundle that an accept would load into the slot
    always_comb begin
        w_load           = '0;
        w_load.opcode    = w_opcode;
        w_load.funct     = instruction[5:0];
        w_load.rs        = w_rs;
        w_load.rt        = w_rt;
        w_load.rd        = instruction[15:11];
        w_load.operand_a = w_operand_a;
        w_load.operand_b = w_operand_b;
        w_load.immediate = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
        w_load.pc        = pcIn;
    end

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next slot state: flush beats accept, accept beats hand-off
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else if (w_accept) begin
            w_state_next = ST_FULL;
        end else if ((r_state == ST_FULL) && outReady) begin
            w_state_next = ST_EMPTY;
        end
    end

    // Slot contents: load on accept, otherwise refresh held operands from WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (w_accept) begin
            r_slot <= w_load;
        end else if (w_hold && wbRegWrite && (wbWriteAddress != '0)) begin
            if (wbWriteAddress == r_slot.rs) begin
                r_slot.operand_a <= wbWriteData;
            end
            if (wbWriteAddress == r_slot.rt) begin
                r_slot.operand_b <= wbWriteData;
            end
        end
    end

    // Saturating count of cycles lost to load-use hazards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign outValid     = (r_state == ST_FULL);
    assign outOperandA  = r_slot.operand_a;
    assign outOperandB  = r_slot.operand_b;
    assign outImmediate = r_slot.immediate;
    assign outOpcode    = r_slot.opcode;
    assign outFunct     = r_slot.funct;
    assign outRs        = r_slot.rs;
    assign outRt        = r_slot.rt;
    assign outRd        = r_slot.rd;
    assign outPc        = r_slot.pc;
    assign stallCount   = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a scoreboard of expected slot contents.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] instruction;
    logic [31:0] pcIn;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        wbRegWrite;
    logic [4:0]  wbWriteAddress;
    logic [31:0] wbWriteData;
    logic        exMemRead;
    logic [4:0]  exWriteAddress;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outOperandA;
    logic [31:0] outOperandB;
    logic [31:0] outImmediate;
    logic [5:0]  outOpcode;
    logic [5:0]  outFunct;
    logic [4:0]  outRs;
    logic [4:0]  outRt;
    logic [4:0]  outRd;
    logic [31:0] outPc;
    logic [15:0] stallCount;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_stall = '0;

    always #5 clk = ~clk;

    operand_fetch_stage #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inValid        (inValid),
        .inReady        (inReady),
        .instruction    (instruction),
        .pcIn           (pcIn),
        .readAddress1   (readAddress1),
        .readAddress2   (readAddress2),
        .readData1      (readData1),
        .readData2      (readData2),
        .wbRegWrite     (wbRegWrite),
        .wbWriteAddress (wbWriteAddress),
        .wbWriteData    (wbWriteData),
        .exMemRead      (exMemRead),
        .exWriteAddress (exWriteAddress),
        .flush          (flush),
        .outValid       (outValid),
        .outReady       (outReady),
        .outOperandA    (outOperandA),
        .outOperandB    (outOperandB),
        .outImmediate   (outImmediate),
        .outOpcode      (outOpcode),
        .outFunct       (outFunct),
        .outRs          (outRs),
        .outRt          (outRt),
        .outRd          (outRd),
        .outPc          (outPc),
        .stallCount     (stallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [15:0] lo;
        lo      = ins[15:0];
        e.op    = ins[31:26];
        e.funct = ins[5:0];
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.rd    = ins[15:11];
        e.imm   = lo[15] ? {16'hFFFF, lo} : {16'h0000, lo};
        e.pc    = pc;
        e.a     = a;
        e.b     = b;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic exm, input logic [4:0] exa,
                         input logic fl, input logic ordy);
        inValid = v; instruction = ins; pcIn = pc; readData1 = rd1; readData2 = rd2;
        wbRegWrite = wbw; wbWriteAddress = wba; wbWriteData = wbd;
        exMemRead = exm; exWriteAddress = exa; flush = fl; outReady = ordy;
    endtask

    task automatic check_slot(input string tag);
        chk({tag, "/outValid"}, 32'(outValid), 32'(exp_q.size() > 0));
        chk({tag, "/stallCount"}, 32'(stallCount), 32'(exp_stall));
        if (exp_q.size() > 0) begin
            chk({tag, "/A"}, outOperandA, exp_q[0].a);
            chk({tag, "/B"}, outOperandB, exp_q[0].b);
            chk({tag, "/imm"}, outImmediate, exp_q[0].imm);
            chk({tag, "/pc"}, outPc, exp_q[0].pc);
            chk({tag, "/dec"}, {outOpcode, outFunct, outRs, outRt, outRd, 5'd0},
                {exp_q[0].op, exp_q[0].funct, exp_q[0].rs, exp_q[0].rt, exp_q[0].rd, 5'd0});
        end
        $display("step %-10s inValid=%0b outValid=%0b A=%h B=%h rd=%0d stall=%0d",
                 tag, inValid, outValid, outOperandA, outOperandB, outRd, stallCount);
    endtask

    // Inputs are already driven at a negedge; check inReady, clock, update model, check slot
    task automatic step(input string tag, input logic exp_ready,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
        logic acc;
        #1;
        chk({tag, "/inReady"}, 32'(inReady), 32'(exp_ready));
        acc = inValid && exp_ready;
        if (inValid && !exp_ready && !flush && (exp_q.size() == 0 || outReady))
            exp_stall = exp_stall + 1'b1;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && !outReady && wbRegWrite && wbWriteAddress != 0) begin
                if (exp_q[0].rs == wbWriteAddress) exp_q[0].a = wbWriteData;
                if (exp_q[0].rt == wbWriteAddress) exp_q[0].b = wbWriteData;
            end
            if (exp_q.size() > 0 && outReady) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(mk(instruction, pcIn, exp_a, exp_b));
        end
        #1;
        check_slot(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1);
        #12;
        check_slot("reset");
        chk("reset/A0", outOperandA, 32'h0);
        chk("reset/pc0", outPc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2
        drive(1, 32'h00221820, 32'h4, 32'd5, 32'd7, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1);
        step("add", 1, 32'd5, 32'd7);
        // load in EX writes $1: one bubble, one stall
        drive(1, 32'h00221820, 32'h8, 32'd5, 32'd7, 0, 5'd0, 32'h0, 1, 5'd1, 0, 1);
        step("hazard", 0, 32'h0, 32'h0);
        drive(1, 32'h00221820, 32'h8, 32'd5, 32'd7, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1);
        step("afterhaz", 1, 32'd5, 32'd7);
        // same-cycle WB to $2 is bypassed
        drive(1, 32'h00221820, 32'hC, 32'd5, 32'd0, 1, 5'd2, 32'hAAAAAAAA, 0, 5'd0, 0, 1);
        step("wbbypass", 1, 32'd5, 32'hAAAAAAAA);
        // held slot, WB to $1 refreshes A only
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 5'd1, 32'h12345678, 0, 5'd0, 0, 0);
        step("refresh", 0, 32'h0, 32'h0);
        // held slot, new instruction waits, no stall counted
        drive(1, 32'h8C000004, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        step("hold", 0, 32'h0, 32'h0);
        // lw $0,4($0): zero operands, load writing $0 does not stall
        drive(1, 32'h8C000004, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 5'd0, 0, 1);
        step("zero", 1, 32'h0, 32'h0);
        // beq $1,$2,-1 with load to $2 in EX: rt is a source, stall
        drive(1, 32'h1022FFFF, 32'h14, 32'd3, 32'd4, 0, 5'd0, 32'h0, 1, 5'd2, 0, 1);
        step("beqhaz", 0, 32'h0, 32'h0);
        drive(1, 32'h1022FFFF, 32'h14, 32'd3, 32'd4, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1);
        step("beq", 1, 32'd3, 32'd4);
        // lw $2,8($1) with load to $2: rt is a destination only, no stall
        drive(1, 32'h8C220008, 32'h18, 32'd10, 32'd11, 0, 5'd0, 32'h0, 1, 5'd2, 0, 1);
        step("lwnort", 1, 32'd10, 32'd11);
        // j with nonzero rs bits and load to $1: rs field not a source
        drive(1, 32'h08200000, 32'h1C, 32'd20, 32'd21, 0, 5'd0, 32'h0, 1, 5'd1, 0, 1);
        step("jnors", 1, 32'd20, 32'd0);
        // flush while full with a new instruction offered
        drive(1, 32'h00221820, 32'h20, 32'd1, 32'd2, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
        step("flush", 0, 32'h0, 32'h0);
        // accept, then asynchronous reset in the middle of the low phase
        drive(1, 32'h00221820, 32'h40, 32'd9, 32'd8, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
        step("prereset", 1, 32'd9, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_stall = '0;
        check_slot("asyncrst");
        chk("asyncrst/A0", outOperandA, 32'h0);
        chk("asyncrst/rd0", 32'(outRd), 32'h0);
        inValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h00221820, 32'h40, 32'd9, 32'd8, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1);
        step("represent", 1, 32'd9, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
